// File: rtl/bcd_counter_chain.sv
// bcd_counter_chain: cascaded up/down BCD digits with per-digit terminal values,
// saturating parallel load, combinational carry/borrow out and a sticky wrap flag.
// Optional lap capture register enabled by defining BCD_LAP_CAPTURE_EN.
module bcd_counter_chain #(
    parameter int                      NUM_DIGITS = 4,
    parameter logic [4*NUM_DIGITS-1:0] DIGIT_MAX  = {NUM_DIGITS{4'd9}}
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      c_in,
    input  logic                      up_dn,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   load_val,
    input  logic                      lap,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic [4*NUM_DIGITS-1:0]   lap_digits,
    output logic                      c_out,
    output logic                      wrapped
);

    localparam int W = 4 * NUM_DIGITS;

    logic [W-1:0]          r_digits;
    logic                  r_wrapped;
    logic [NUM_DIGITS-1:0] w_en;
    logic [NUM_DIGITS-1:0] w_term;
    logic [W-1:0]          w_load_sat;
    logic                  w_c_out;

    // Clamp every load field to its digit's terminal value so out-of-range
    // digit values can never be reached.
    function automatic logic [W-1:0] saturate(input logic [W-1:0] v);
        logic [W-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] > DIGIT_MAX[4*i +: 4])
                s[4*i +: 4] = DIGIT_MAX[4*i +: 4];
            else
                s[4*i +: 4] = v[4*i +: 4];
        end
        return s;
    endfunction

    assign w_load_sat = saturate(load_val);

    // Terminal detect and enable chain; load and reset suppress all counting
    // (and therefore c_out) in the same cycle.
    always_comb begin
        logic w_run;
        logic w_t;
        w_en   = '0;
        w_term = '0;
        w_run  = c_in & ~load & ~reset;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (up_dn)
                w_t = (r_digits[4*i +: 4] == DIGIT_MAX[4*i +: 4]);
            else
                w_t = (r_digits[4*i +: 4] == 4'd0);
            w_term[i] = w_t;
            w_en[i]   = w_run;
            w_run     = w_run & w_t;
        end
    end

    assign w_c_out = w_en[NUM_DIGITS-1] & w_term[NUM_DIGITS-1];

    // Digit register: reset > load > count > hold, all digits on one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_digits <= '0;
        end else if (load) begin
            r_digits <= w_load_sat;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_en[i]) begin
                    if (up_dn)
                        r_digits[4*i +: 4] <= w_term[i] ? 4'd0 : r_digits[4*i +: 4] + 4'd1;
                    else
                        r_digits[4*i +: 4] <= w_term[i] ? DIGIT_MAX[4*i +: 4]
                                                        : r_digits[4*i +: 4] - 4'd1;
                end
            end
        end
    end

    // Sticky wrap flag: set when the whole chain rolls over, cleared by reset or load.
    always_ff @(posedge clk) begin
        if (reset)
            r_wrapped <= 1'b0;
        else if (load)
            r_wrapped <= 1'b0;
        else if (w_c_out)
            r_wrapped <= 1'b1;
    end

`ifdef BCD_LAP_CAPTURE_EN
    logic [W-1:0] r_lap;

    // Lap capture samples the pre-edge digits, independent of load or counting.
    always_ff @(posedge clk) begin
        if (reset)
            r_lap <= '0;
        else if (lap)
            r_lap <= r_digits;
    end

    assign lap_digits = r_lap;
`else
    logic w_unused_lap;
    assign w_unused_lap = lap;
    assign lap_digits   = '0;
`endif

    assign digits  = r_digits;
    assign wrapped = r_wrapped;
    assign c_out   = w_c_out;

endmodule

// File: tb/tb_bcd_counter_chain.sv
module tb_bcd_counter_chain;

    localparam int          ND    = 4;
    localparam logic [15:0] MAXV  = 16'h5959;
    localparam int          TOTAL = 3600;

    logic        clk = 1'b0;
    logic        reset, c_in, up_dn, load, lap;
    logic [15:0] load_val;
    logic [15:0] digits, lap_digits;
    logic        c_out, wrapped;

    int total = 0;
    int bad   = 0;

    // reference model: chain value as a mixed-radix integer
    int          m_val  = 0;
    logic        m_wrap = 1'b0;
    logic [15:0] m_lap  = 16'h0;
    logic        obs_cout, exp_cout;

    bcd_counter_chain #(.NUM_DIGITS(ND), .DIGIT_MAX(MAXV)) dut (
        .clk(clk), .reset(reset), .c_in(c_in), .up_dn(up_dn), .load(load),
        .load_val(load_val), .lap(lap), .digits(digits), .lap_digits(lap_digits),
        .c_out(c_out), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    function automatic int radix(input int i);
        logic [15:0] m;
        m = MAXV;
        return int'(m[4*i +: 4]) + 1;
    endfunction

    function automatic int to_val(input logic [15:0] d);
        int v, mul;
        v = 0; mul = 1;
        for (int i = 0; i < ND; i++) begin
            v += int'(d[4*i +: 4]) * mul;
            mul *= radix(i);
        end
        return v;
    endfunction

    function automatic logic [15:0] to_dig(input int v);
        logic [15:0] d;
        int r;
        d = '0; r = v;
        for (int i = 0; i < ND; i++) begin
            d[4*i +: 4] = 4'(r % radix(i));
            r = r / radix(i);
        end
        return d;
    endfunction

    function automatic logic [15:0] sat(input logic [15:0] lv);
        logic [15:0] d;
        for (int i = 0; i < ND; i++) begin
            if (int'(lv[4*i +: 4]) > radix(i) - 1) d[4*i +: 4] = 4'(radix(i) - 1);
            else                                   d[4*i +: 4] = lv[4*i +: 4];
        end
        return d;
    endfunction

    function automatic logic [15:0] exp_lap_out();
`ifdef BCD_LAP_CAPTURE_EN
        return m_lap;
`else
        return 16'h0000;
`endif
    endfunction

    // drive one cycle, sample c_out mid-cycle, advance model, step past the edge
    task automatic cycle(input logic r, input logic ld, input logic [15:0] lv,
                         input logic ci, input logic ud, input logic lp);
        reset = r; load = ld; load_val = lv; c_in = ci; up_dn = ud; lap = lp;
        #1;
        obs_cout = c_out;
        exp_cout = !r && !ld && ci && (ud ? (m_val == TOTAL - 1) : (m_val == 0));
        if (r) begin
            m_val = 0; m_wrap = 1'b0; m_lap = 16'h0;
        end else begin
            if (lp) m_lap = to_dig(m_val);
            if (ld) begin
                m_val = to_val(sat(lv)); m_wrap = 1'b0;
            end else if (ci) begin
                if (exp_cout) m_wrap = 1'b1;
                m_val = ud ? (m_val + 1) % TOTAL : (m_val + TOTAL - 1) % TOTAL;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        cycle(1, 1, 16'h1234, 1, 1, 1);
        total++; if (digits !== 16'h0000) begin bad++; $display("FAIL reset_digits got=%h want=0000", digits); end
        total++; if (wrapped !== 1'b0) begin bad++; $display("FAIL reset_wrapped got=%b want=0", wrapped); end
        total++; if (lap_digits !== 16'h0000) begin bad++; $display("FAIL reset_lap got=%h want=0000", lap_digits); end
    endtask

    task automatic test_count_up_60();
        int hits;
        hits = 0;
        cycle(1, 0, 16'h0, 0, 1, 0);
        for (int i = 0; i < 60; i++) begin
            cycle(0, 0, 16'h0, 1, 1, 0);
            if (obs_cout) hits++;
        end
        total++; if (digits !== 16'h0100) begin bad++; $display("FAIL count60_digits got=%h want=0100", digits); end
        total++; if (hits !== 0) begin bad++; $display("FAIL count60_cout got=%0d want=0", hits); end
        total++; if (wrapped !== 1'b0) begin bad++; $display("FAIL count60_wrapped got=%b want=0", wrapped); end
    endtask

    task automatic test_wrap_up();
        cycle(0, 1, 16'h5959, 0, 1, 0);
        cycle(0, 1, 16'h5959, 1, 1, 0);
        total++; if (obs_cout !== 1'b0) begin bad++; $display("FAIL load_masks_cout got=%b want=0", obs_cout); end
        total++; if (digits !== 16'h5959) begin bad++; $display("FAIL load_max got=%h want=5959", digits); end
        cycle(0, 0, 16'h0, 1, 1, 0);
        total++; if (obs_cout !== 1'b1) begin bad++; $display("FAIL wrap_up_cout got=%b want=1", obs_cout); end
        total++; if (digits !== 16'h0000) begin bad++; $display("FAIL wrap_up_digits got=%h want=0000", digits); end
        total++; if (wrapped !== 1'b1) begin bad++; $display("FAIL wrap_up_wrapped got=%b want=1", wrapped); end
    endtask

    task automatic test_wrap_down();
        cycle(1, 0, 16'h0, 0, 0, 0);
        cycle(0, 0, 16'h0, 1, 0, 0);
        total++; if (obs_cout !== 1'b1) begin bad++; $display("FAIL wrap_dn_cout got=%b want=1", obs_cout); end
        total++; if (digits !== 16'h5959) begin bad++; $display("FAIL wrap_dn_digits got=%h want=5959", digits); end
        total++; if (wrapped !== 1'b1) begin bad++; $display("FAIL wrap_dn_wrapped got=%b want=1", wrapped); end
    endtask

    task automatic test_load_sat();
        cycle(0, 1, 16'h7A3F, 0, 1, 0);
        total++; if (digits !== 16'h5939) begin bad++; $display("FAIL load_sat_digits got=%h want=5939", digits); end
        total++; if (wrapped !== 1'b0) begin bad++; $display("FAIL load_sat_wrapped got=%b want=0", wrapped); end
    endtask

    task automatic test_reset_priority();
        cycle(0, 1, 16'h0122, 0, 1, 0);
        cycle(0, 0, 16'h0, 1, 1, 0);
        total++; if (digits !== 16'h0123) begin bad++; $display("FAIL prio_setup got=%h want=0123", digits); end
        cycle(1, 1, 16'h4444, 1, 1, 1);
        total++; if (obs_cout !== 1'b0) begin bad++; $display("FAIL prio_cout got=%b want=0", obs_cout); end
        total++; if (digits !== 16'h0000) begin bad++; $display("FAIL prio_digits got=%h want=0000", digits); end
        total++; if (wrapped !== 1'b0) begin bad++; $display("FAIL prio_wrapped got=%b want=0", wrapped); end
    endtask

    task automatic test_lap();
        logic [15:0] want;
        cycle(0, 1, 16'h0122, 0, 1, 0);
        cycle(0, 0, 16'h0, 1, 1, 0);
        cycle(0, 0, 16'h0, 1, 1, 1);
`ifdef BCD_LAP_CAPTURE_EN
        want = 16'h0123;
`else
        want = 16'h0000;
`endif
        total++; if (digits !== 16'h0124) begin bad++; $display("FAIL lap_counting got=%h want=0124", digits); end
        total++; if (lap_digits !== want) begin bad++; $display("FAIL lap_capture got=%h want=%h", lap_digits, want); end
        cycle(0, 0, 16'h0, 1, 1, 0);
        cycle(0, 0, 16'h0, 1, 1, 0);
        total++; if (lap_digits !== want) begin bad++; $display("FAIL lap_hold got=%h want=%h", lap_digits, want); end
        total++; if (digits !== 16'h0126) begin bad++; $display("FAIL lap_count2 got=%h want=0126", digits); end
        cycle(0, 1, 16'h0200, 1, 1, 1);
`ifdef BCD_LAP_CAPTURE_EN
        want = 16'h0126;
`else
        want = 16'h0000;
`endif
        total++; if (lap_digits !== want) begin bad++; $display("FAIL lap_with_load got=%h want=%h", lap_digits, want); end
        total++; if (digits !== 16'h0200) begin bad++; $display("FAIL lap_load_digits got=%h want=0200", digits); end
    endtask

    task automatic test_random();
        logic r, ld, ci, ud, lp;
        logic [15:0] lv;
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 59) == 0);
            ld = ($urandom_range(0, 24) == 0);
            ci = ($urandom_range(0, 3) != 0);
            ud = (n < 1500) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
            lp = ($urandom_range(0, 7) == 0);
            lv = 16'($urandom);
            if ($urandom_range(0, 3) == 0) lv = (ud ? 16'h5958 : 16'h0001);
            cycle(r, ld, lv, ci, ud, lp);
            total++; if (obs_cout !== exp_cout) begin bad++; $display("FAIL rnd_cout n=%0d got=%b want=%b", n, obs_cout, exp_cout); end
            total++; if (digits !== to_dig(m_val)) begin bad++; $display("FAIL rnd_digits n=%0d got=%h want=%h", n, digits, to_dig(m_val)); end
            total++; if (wrapped !== m_wrap) begin bad++; $display("FAIL rnd_wrapped n=%0d got=%b want=%b", n, wrapped, m_wrap); end
            total++; if (lap_digits !== exp_lap_out()) begin bad++; $display("FAIL rnd_lap n=%0d got=%h want=%h", n, lap_digits, exp_lap_out()); end
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; load_val = '0; c_in = 1'b0; up_dn = 1'b1; lap = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_count_up_60();
        test_wrap_up();
        test_wrap_down();
        test_load_sat();
        test_reset_priority();
        test_lap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
